// File: rtl/inst_fetch.sv
// Instruction fetch: PC register driving a combinational ROM, 2-entry {pc, data} queue to decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky fault and halt fetch.
module inst_fetch #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_fault
);

    localparam int DEPTH = 2;
    typedef logic [1:0] cnt_t;

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] ent_pc_reg   [DEPTH];
    logic [ADDR_W-1:0] ent_pc_next  [DEPTH];
    logic [DATA_W-1:0] ent_data_reg [DEPTH];
    logic [DATA_W-1:0] ent_data_next[DEPTH];
    cnt_t              count_reg, count_next, count_after_pop;
    logic              halted_reg, halted_next;
    logic              fault_reg, fault_next;
    logic              pop, push;
    logic [ADDR_W-1:0] target_pc;

    assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Slot 0 is always the head, so outputs come straight from registers and
    // keep their last value once the queue empties.
    assign rom_addr    = pc_reg;
    assign inst_valid  = (count_reg != 2'd0);
    assign inst_data   = ent_data_reg[0];
    assign inst_pc     = ent_pc_reg[0];
    assign fetch_fault = fault_reg;

    assign pop             = inst_valid && inst_ready;
    assign push            = !redirect_valid && !halted_reg &&
                             ((count_reg < cnt_t'(DEPTH)) || pop);
    assign count_after_pop = count_reg - cnt_t'(pop);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fault_next  = fault_reg | misaligned;
    assign halted_next = halted_reg | misaligned;
`else
    // Low target bits are simply dropped when the trap is not built in.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign fault_next      = 1'b0;
    assign halted_next     = 1'b0;
`endif

    always_comb begin
        pc_next    = pc_reg;
        count_next = count_after_pop;
        if (redirect_valid) begin
            pc_next    = target_pc;
            count_next = '0;
        end else if (push) begin
            pc_next    = pc_reg + ADDR_W'(4);
            count_next = count_after_pop + 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_pc_next[i]   = ent_pc_reg[i];
            ent_data_next[i] = ent_data_reg[i];
        end
        // A flush leaves entry contents alone; only the count is cleared.
        if (!redirect_valid && pop && (count_reg == 2'd2)) begin
            ent_pc_next[0]   = ent_pc_reg[1];
            ent_data_next[0] = ent_data_reg[1];
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                ent_pc_next[0]   = pc_reg;
                ent_data_next[0] = rom_data;
            end else begin
                ent_pc_next[1]   = pc_reg;
                ent_data_next[1] = rom_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            count_reg  <= '0;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_reg[i]   <= '0;
                ent_data_reg[i] <= '0;
            end
        end else begin
            pc_reg     <= pc_next;
            count_reg  <= count_next;
            halted_reg <= halted_next;
            fault_reg  <= fault_next;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_reg[i]   <= ent_pc_next[i];
                ent_data_reg[i] <= ent_data_next[i];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle-by-cycle vector table plus hand-written redirect sequences.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [6:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [6:0]  inst_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    inst_fetch #(.ADDR_W(7), .DATA_W(32), .RESET_PC(7'h00)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    assign rom_data = 32'hA500_0000 | {25'd0, rom_addr};

    // Each record: inputs for this cycle, and the outputs expected during this cycle.
    typedef struct {
        logic        rst;
        logic        rv;
        logic [6:0]  rpc;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [6:0]  epc;
        logic [31:0] edata;
        logic [6:0]  erom;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    function automatic vec_t mk(logic r, logic rv, logic [6:0] rpc, logic rdy, logic chk,
                                logic ev, logic [6:0] epc, logic [31:0] ed, logic [6:0] erom, logic ef);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.chk = chk;
        v.ev = ev; v.epc = epc; v.edata = ed; v.erom = erom; v.ef = ef;
        return v;
    endfunction

    function automatic logic [31:0] romv(logic [6:0] a);
        return 32'hA500_0000 | {25'd0, a};
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(logic r, logic rv, logic [6:0] rpc, logic rdy);
        rst = r; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    endtask

    // Apply inputs for one cycle and return at the following negedge.
    task automatic cyc(logic r, logic rv, logic [6:0] rpc, logic rdy);
        drive(r, rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic check_state(string tag, logic ev, logic [6:0] epc, logic [31:0] ed,
                               logic [6:0] erom, logic ef);
        chk({tag, ".valid"}, 32'(inst_valid), 32'(ev));
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(erom));
        chk({tag, ".fault"}, 32'(fetch_fault), 32'(ef));
        chk({tag, ".inst_pc"}, 32'(inst_pc), 32'(epc));
        chk({tag, ".inst_data"}, inst_data, ed);
        $display("cycle %s valid=%0d pc=%h data=%h rom=%h fault=%0d",
                 tag, inst_valid, inst_pc, inst_data, rom_addr, fetch_fault);
    endtask

    initial begin
        logic [6:0] p;
        drive(1'b1, 1'b0, 7'h00, 1'b0);

        // Reset, then the stall scenario: ready low from cycle 1 through cycle 6.
        vecs.push_back(mk(1, 0, 7'h00, 0, 0, 0, 7'h00, 32'h0, 7'h00, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 0, 7'h00, 32'h0, 7'h00, 0));
        vecs.push_back(mk(0, 0, 7'h00, 0, 1, 1, 7'h00, romv(7'h00), 7'h04, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 7'h00, 0, 1, 1, 7'h00, romv(7'h00), 7'h08, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 1, 7'h00, romv(7'h00), 7'h08, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 1, 7'h04, romv(7'h04), 7'h0C, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 1, 7'h08, romv(7'h08), 7'h10, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 1, 7'h0C, romv(7'h0C), 7'h14, 0));
        // Queue holds 0x10/0x14; redirect to 0x40 while head is being accepted.
        vecs.push_back(mk(0, 1, 7'h40, 1, 1, 1, 7'h10, romv(7'h10), 7'h18, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 0, 7'h10, romv(7'h10), 7'h40, 0));
        // Free run 0x40..0x7C then wrap to 0x00.
        for (int k = 0; k < 16; k++) begin
            p = 7'(8'h40 + 8'(4 * k));
            vecs.push_back(mk(0, 0, 7'h00, 1, 1, 1, p, romv(p), p + 7'h04, 0));
        end
        vecs.push_back(mk(0, 0, 7'h00, 0, 1, 1, 7'h00, romv(7'h00), 7'h04, 0));
        // Full queue plus pending redirect, then reset wins.
        vecs.push_back(mk(1, 1, 7'h40, 1, 1, 1, 7'h00, romv(7'h00), 7'h08, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 0, 7'h00, 32'h0, 7'h00, 0));
        // Misaligned redirect to 0x22.
        vecs.push_back(mk(0, 1, 7'h22, 1, 1, 1, 7'h00, romv(7'h00), 7'h04, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 0, 7'h00, romv(7'h00), 7'h20, TRAP));
        if (TRAP) begin
            vecs.push_back(mk(0, 0, 7'h00, 1, 1, 0, 7'h00, romv(7'h00), 7'h20, 1));
            vecs.push_back(mk(1, 0, 7'h00, 1, 1, 0, 7'h00, romv(7'h00), 7'h20, 1));
        end else begin
            vecs.push_back(mk(0, 0, 7'h00, 1, 1, 1, 7'h20, romv(7'h20), 7'h24, 0));
            vecs.push_back(mk(1, 0, 7'h00, 1, 1, 1, 7'h24, romv(7'h24), 7'h28, 0));
        end
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 0, 7'h00, 32'h0, 7'h00, 0));
        vecs.push_back(mk(0, 0, 7'h00, 1, 1, 1, 7'h00, romv(7'h00), 7'h04, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].chk)
                check_state($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].edata,
                            vecs[i].erom, vecs[i].ef);
            cyc(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
        end

        // Redirect into a full, stalled queue, then a back-to-back second redirect.
        cyc(1, 0, 7'h00, 0);
        cyc(0, 0, 7'h00, 0);
        cyc(0, 0, 7'h00, 0);
        check_state("h_full", 1, 7'h00, romv(7'h00), 7'h08, 0);
        cyc(0, 1, 7'h30, 0);
        check_state("h_redir1", 0, 7'h00, romv(7'h00), 7'h30, 0);
        cyc(0, 1, 7'h50, 1);
        check_state("h_redir2", 0, 7'h00, romv(7'h00), 7'h50, 0);
        cyc(0, 0, 7'h00, 1);
        check_state("h_target", 1, 7'h50, romv(7'h50), 7'h54, 0);
        cyc(0, 0, 7'h00, 1);
        check_state("h_next", 1, 7'h54, romv(7'h54), 7'h58, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
